// File: rtl/pipeline_memory_arbiter.sv
// Arbiter that shares one request/acknowledge memory bus between the
// instruction-fetch and data-access requesters of the pipeline. Data has
// priority. The ready mask lets a pending fetch win the next IDLE cycle.
// An access that waits too long is aborted, and a sticky timeout flag is set.
//
// Handshake: each requester holds its request level until its one-cycle
// ready pulse. The bus holds bus_request high for the whole access, and an
// access completes at the first rising edge where bus_acknowledge is 1.
module pipeline_memory_arbiter #(
    parameter int unsigned TIMEOUT_WIDTH  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_request,
    input  logic [31:0] if_address,
    output logic [31:0] if_instruction,
    output logic        if_ready,
    input  logic        mem_request,
    input  logic        mem_writeEnable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_writeData,
    input  logic [3:0]  mem_byteEnable,
    output logic [31:0] mem_readData,
    output logic        mem_ready,
    output logic        pipeline_stall,
    output logic        bus_request,
    output logic        bus_writeEnable,
    output logic [31:0] bus_address,
    output logic [31:0] bus_writeData,
    output logic [3:0]  bus_byteEnable,
    input  logic        bus_acknowledge,
    input  logic [31:0] bus_readData,
    output logic        bus_timeout,
    output logic [1:0]  debugState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arbState_t;

    localparam logic [TIMEOUT_WIDTH-1:0] waitLimit = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    arbState_t                state;
    arbState_t                nextState;
    logic [TIMEOUT_WIDTH-1:0] waitCount;
    logic                     accessDone;
    logic                     timedOut;
    logic                     effFetch;
    logic                     effData;

    logic [31:0] latchedAddress;
    logic [31:0] latchedWriteData;
    logic [3:0]  latchedByteEnable;
    logic        latchedWriteEnable;
    logic [31:0] instructionQ;
    logic [31:0] readDataQ;
    logic        ifReadyQ;
    logic        memReadyQ;
    logic        timeoutQ;

    // A request is ignored in the cycle its own ready pulse is high.
    // Without this mask, a held request would start a second access.
    assign effFetch = if_request & ~if_ready;
    assign effData  = mem_request & ~mem_ready;

    // Next-state logic, plus completion and abort detection for the active access.
    always_comb begin
        nextState  = state;
        accessDone = 1'b0;
        timedOut   = 1'b0;
        case (state)
            IDLE: begin
                if (effData) begin
                    nextState = DATA;
                end else if (effFetch) begin
                    nextState = FETCH;
                end
            end
            FETCH, DATA: begin
                if (bus_acknowledge) begin
                    nextState  = IDLE;
                    accessDone = 1'b1;
                end else if (waitCount == waitLimit) begin
                    nextState  = IDLE;
                    accessDone = 1'b1;
                    timedOut   = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State register. Reset returns to IDLE at once, which drops bus_request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Wait counter: counts unacknowledged bus cycles and clears when the access ends.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            waitCount <= '0;
        end else if (state != IDLE && !accessDone) begin
            waitCount <= waitCount + 1'b1;
        end else begin
            waitCount <= '0;
        end
    end

    // Latch the winning requester's fields when an access starts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            latchedAddress     <= '0;
            latchedWriteData   <= '0;
            latchedByteEnable  <= '0;
            latchedWriteEnable <= 1'b0;
        end else if (state == IDLE) begin
            if (effData) begin
                latchedAddress     <= mem_address;
                latchedWriteData   <= mem_writeData;
                latchedByteEnable  <= mem_byteEnable;
                latchedWriteEnable <= mem_writeEnable;
            end else if (effFetch) begin
                latchedAddress     <= if_address;
                latchedByteEnable  <= 4'b1111;
                latchedWriteEnable <= 1'b0;
            end
        end
    end

    // Completion pulses and returned data. A timeout returns zero.
    // A store leaves the load data register untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ifReadyQ     <= 1'b0;
            memReadyQ    <= 1'b0;
            instructionQ <= '0;
            readDataQ    <= '0;
        end else begin
            ifReadyQ  <= (state == FETCH) && accessDone;
            memReadyQ <= (state == DATA) && accessDone;
            if (state == FETCH && accessDone) begin
                instructionQ <= timedOut ? 32'h0000_0000 : bus_readData;
            end
            if (state == DATA && accessDone && !latchedWriteEnable) begin
                readDataQ <= timedOut ? 32'h0000_0000 : bus_readData;
            end
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeoutQ <= 1'b0;
        end else if (timedOut) begin
            timeoutQ <= 1'b1;
        end
    end

    assign bus_request     = (state != IDLE);
    assign bus_writeEnable = (state == DATA) && latchedWriteEnable;
    assign bus_byteEnable  = (state == FETCH) ? 4'b1111 :
                             (state == DATA)  ? latchedByteEnable : 4'b0000;
    assign bus_address     = latchedAddress;
    assign bus_writeData   = latchedWriteData;
    assign bus_timeout     = timeoutQ;
    assign if_ready        = ifReadyQ;
    assign mem_ready       = memReadyQ;
    assign if_instruction  = instructionQ;
    assign mem_readData    = readDataQ;
    assign pipeline_stall  = effFetch | effData;
    assign debugState      = state;

endmodule
